// File: rtl/step_pkg.sv
// Shared constants for the stepper sequencer: coil pattern table,
// default speed clamp and direction encoding.
package step_pkg;

  localparam int MAX_SPEED_DEF = 6;

  localparam logic FWD = 1'b1;
  localparam logic REV = 1'b0;

  // Even entries are single-coil wave drive, odd entries the in-between half steps.
  localparam logic [3:0] COIL_TABLE [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

endpackage

// File: rtl/speed_sync.sv
// Brings the key-clocked speed code into the clk domain, waits for it to be
// stable across two synchronised samples, then clamps it to MAX_SPEED.
module speed_sync
  import step_pkg::*;
#(
  parameter int MAX_SPEED = MAX_SPEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] speedValue,
  output logic [2:0] effSpeed
);

  localparam logic [3:0] MAX4 = 4'(MAX_SPEED);

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [2:0] eff_reg;
  logic [2:0] eff_next;

  always_comb begin
    eff_next = eff_reg;
    // sync1 holds the sample that follows sync2, so equality means two
    // consecutive synchronised samples agreed.
    if (sync1_reg == sync2_reg) begin
      if (sync2_reg > MAX4) eff_next = MAX4[2:0];
      else                  eff_next = sync2_reg[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      eff_reg   <= '0;
    end else begin
      sync1_reg <= speedValue;
      sync2_reg <= sync1_reg;
      eff_reg   <= eff_next;
    end
  end

  assign effSpeed = eff_reg;

endmodule

// File: rtl/step_sequencer.sv
// Stepper coil sequencer: phase accumulator sets the step rate from the
// qualified speed code; each carry advances the coil pattern and position.
module step_sequencer
  import step_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int INC       = 64,
  parameter int MAX_SPEED = MAX_SPEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        dir,
  input  logic        halfStep,
  input  logic [3:0]  speedValue,
  output logic [3:0]  coils,
  output logic        stepPulse,
  output logic [15:0] position
);

  localparam int AW1 = ACC_W + 1;

  logic [2:0]       eff_speed;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [2:0]       idx_reg, idx_next;
  logic [15:0]      pos_reg, pos_next;
  logic [3:0]       coils_reg, coils_next;
  logic             pulse_reg, pulse_next;
  logic [ACC_W:0]   step_inc;
  logic [ACC_W:0]   acc_sum;

  speed_sync #(
    .MAX_SPEED (MAX_SPEED)
  ) u_speed_sync (
    .clk        (clk),
    .rst        (rst),
    .speedValue (speedValue),
    .effSpeed   (eff_speed)
  );

  assign step_inc = AW1'(eff_speed) * AW1'(INC);
  assign acc_sum  = {1'b0, acc_reg} + step_inc;

  always_comb begin
    acc_next   = acc_reg;
    idx_next   = idx_reg;
    pos_next   = pos_reg;
    pulse_next = 1'b0;
    // Disable wins over a coincident carry; idx and position simply hold.
    if (!enable) begin
      acc_next = '0;
    end else if (eff_speed != 3'd0) begin
      acc_next = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) begin
        pulse_next = 1'b1;
        if (halfStep) begin
          idx_next = (dir == REV) ? idx_reg - 3'd1 : idx_reg + 3'd1;
        end else if (dir == REV) begin
          idx_next = ((idx_reg + 3'd1) & 3'b110) - 3'd2;
        end else begin
          idx_next = (idx_reg & 3'b110) + 3'd2;
        end
        pos_next = (dir == FWD) ? pos_reg + 16'd1 : pos_reg - 16'd1;
      end
    end
    coils_next = enable ? COIL_TABLE[idx_next] : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg   <= '0;
      idx_reg   <= '0;
      pos_reg   <= '0;
      coils_reg <= '0;
      pulse_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
      pos_reg   <= pos_next;
      coils_reg <= coils_next;
      pulse_reg <= pulse_next;
    end
  end

  assign coils     = coils_reg;
  assign stepPulse = pulse_reg;
  assign position  = pos_reg;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with ACC_W=8, INC=16 (16-cycle period at speed 1).
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dir;
  logic        halfStep;
  logic [3:0]  speedValue;
  logic [3:0]  coils;
  logic        stepPulse;
  logic [15:0] position;

  int n_assert = 0;
  int n_fail   = 0;
  int n;
  int pulses;

  step_sequencer #(
    .ACC_W     (8),
    .INC       (16),
    .MAX_SPEED (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .dir        (dir),
    .halfStep   (halfStep),
    .speedValue (speedValue),
    .coils      (coils),
    .stepPulse  (stepPulse),
    .position   (position)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until stepPulse is seen; returns the edge count or -1 on timeout.
  task automatic wait_step(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (stepPulse) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic ticks_count(input int k, output int p);
    p = 0;
    for (int i = 0; i < k; i++) begin
      tick();
      if (stepPulse) p++;
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; dir = 1'b1; halfStep = 1'b1; speedValue = 4'd1;
    #2;
    check("rst_coils", coils, 4'b0000);
    check("rst_pulse", stepPulse, 1'b0);
    check("rst_pos", position, 16'h0000);
    check("rst_eff", dut.eff_speed, 3'd0);
    #1 rst = 1'b1;

    tick(); tick();
    check("eff_lat2", dut.eff_speed, 3'd0);
    tick();
    check("eff_lat3", dut.eff_speed, 3'd1);

    // Half-step forward at speed 1
    enable = 1'b1;
    ticks_count(15, pulses);
    check("no_early_pulse", pulses, 0);
    check("coils_idx0", coils, 4'b1000);
    check("pos_before", position, 16'd0);
    tick();
    check("step1_pulse", stepPulse, 1'b1);
    check("step1_coils", coils, 4'b1100);
    check("step1_pos", position, 16'd1);
    tick();
    check("pulse_one_cycle", stepPulse, 1'b0);
    wait_step(n);
    check("step2_period", n, 15);
    check("step2_coils", coils, 4'b0100);
    check("step2_pos", position, 16'd2);
    wait_step(n);
    check("step3_period", n, 16);
    check("step3_coils", coils, 4'b0110);
    check("step3_idx", dut.idx_reg, 3'd3);

    // Full-step forward from odd index
    halfStep = 1'b0;
    wait_step(n);
    check("full_fwd1_idx", dut.idx_reg, 3'd4);
    check("full_fwd1_coils", coils, 4'b0010);
    wait_step(n);
    check("full_fwd2_idx", dut.idx_reg, 3'd6);
    check("full_fwd2_coils", coils, 4'b0001);
    check("full_fwd2_pos", position, 16'd5);

    halfStep = 1'b1;
    for (int i = 0; i < 5; i++) wait_step(n);
    check("back_to_idx3", dut.idx_reg, 3'd3);
    check("back_to_idx3_pos", position, 16'd10);

    // Full-step reverse from odd index
    dir = 1'b0; halfStep = 1'b0;
    wait_step(n);
    check("full_rev_idx", dut.idx_reg, 3'd2);
    check("full_rev_coils", coils, 4'b0100);
    check("full_rev_pos", position, 16'd9);

    // Speed change 1 -> 4 right after a step (acc = 0)
    dir = 1'b1; halfStep = 1'b1; speedValue = 4'd4;
    ticks_count(3, pulses);
    check("eff_speed4", dut.eff_speed, 3'd4);
    check("no_glitch_pulse", pulses, 0);
    wait_step(n);
    check("spd4_first", n, 4);
    check("spd4_first_pos", position, 16'd10);
    wait_step(n);
    check("spd4_period", n, 4);
    wait_step(n);
    check("spd4_period2", n, 4);
    check("spd4_coils", coils, 4'b0011);
    check("spd4_pos", position, 16'd12);

    // Clamp
    speedValue = 4'd9;
    ticks_count(3, pulses);
    check("eff_clamp6", dut.eff_speed, 3'd6);
    check("clamp_no_pulse", pulses, 0);

    enable = 1'b0; speedValue = 4'd1;
    tick();
    check("dis_coils", coils, 4'b0000);
    check("dis_pos", position, 16'd12);
    check("dis_pulse", stepPulse, 1'b0);
    tick(); tick();
    check("eff_back1", dut.eff_speed, 3'd1);
    check("dis_idx_hold", dut.idx_reg, 3'd5);

    enable = 1'b1;
    wait_step(n);
    check("reen_period", n, 16);
    check("reen_coils", coils, 4'b0001);
    check("reen_pos", position, 16'd13);

    // Disable on the edge that would step
    ticks_count(15, pulses);
    check("pre_dis_no_pulse", pulses, 0);
    enable = 1'b0;
    tick();
    check("prio_pulse", stepPulse, 1'b0);
    check("prio_coils", coils, 4'b0000);
    check("prio_pos", position, 16'd13);
    check("prio_idx", dut.idx_reg, 3'd6);
    enable = 1'b1;
    wait_step(n);
    check("prio_reen_period", n, 16);
    check("prio_reen_coils", coils, 4'b1001);
    check("prio_reen_pos", position, 16'd14);

    // Asynchronous reset between edges, then reverse from reset
    #3 rst = 1'b0; dir = 1'b0;
    #1;
    check("arst_coils", coils, 4'b0000);
    check("arst_pos", position, 16'd0);
    check("arst_pulse", stepPulse, 1'b0);
    check("arst_eff", dut.eff_speed, 3'd0);
    check("arst_idx", dut.idx_reg, 3'd0);
    #2 rst = 1'b1;
    tick(); tick();
    check("post_rst_eff2", dut.eff_speed, 3'd0);
    tick();
    check("post_rst_eff3", dut.eff_speed, 3'd1);
    wait_step(n);
    check("rev_wrap_period", n, 16);
    check("rev_wrap_idx", dut.idx_reg, 3'd7);
    check("rev_wrap_coils", coils, 4'b1001);
    check("rev_wrap_pos", position, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
